sensor_acq_responder: RTL and testbench
=======================================

# sensor_acq_responder

Sensor-side end of the timing manager's trigger/done handshake. On each accepted `trigger` while enabled, it pulses CONVST to an external converter, waits for BUSY to clear, reads a fixed-length serial frame, latches it, and raises the level `done` the timing manager qualifies with its enable bit. It sits between the timing manager outputs (`trigger`, `en_*`) and one sensor port, for example one AMDS or eddy GPIO slot.

## Interface
Parameters:
- `N_WORDS`, 4, words per frame
- `WORD_W`, 16, bits per word
- `SCLK_DIV`, 4, clk cycles per SCLK half-period (≥1)
- `CONVST_W`, 2, CONVST pulse width in clk cycles (≥1)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous reset, active-high
- `trigger`  in  1  one-cycle trigger pulse from the timing manager
- `en`  in  1  sensor enable (the timing manager's `en_*` bit)
- `timeout_cycles`  in  16  BUSY wait limit (used only with the timeout feature)
- `overrun_clr`  in  1  clears `overrun`
- `busy`  in  1  converter BUSY, already synchronized
- `miso`  in  1  serial data, already synchronized
- `convst`  out  1  convert-start pulse
- `cs_n`  out  1  chip select, active-low
- `sclk`  out  1  serial clock, idles low
- `data`  out  N_WORDS*WORD_W  last good frame; word 0 in the MSBs
- `data_valid`  out  1  one-cycle pulse when `data` updates
- `done`  out  1  level; acquisition complete
- `error`  out  1  last acquisition timed out
- `overrun`  out  1  sticky; a trigger arrived mid-acquisition

## Operation
- Reset values: `convst`=0, `cs_n`=1, `sclk`=0, `data`=0, `data_valid`=0, `done`=0, `error`=0, `overrun`=0. State is IDLE.
- States:
  - IDLE → CONV on `trigger & en`.
  - CONV holds `convst`=1 for CONVST_W cycles → WAIT.
  - In WAIT, the first 2 cycles are guard cycles and `busy` is ignored. After the guard, the first cycle with `busy`=0 → READ.
  - READ shifts N_WORDS*WORD_W bits → DONE.
  - DONE → CONV on `trigger & en`.
- `done`:
  - Cleared in the cycle after a trigger is accepted.
  - Set on entry to DONE and held there.
  - The timing manager sees exactly one rising edge per acquisition.
- READ:
  - `cs_n`=0 for the whole state.
  - Each bit is SCLK_DIV cycles with `sclk`=0, then SCLK_DIV cycles with `sclk`=1.
  - `miso` is sampled on the clk edge that drives `sclk` high. Bits arrive MSB first.
- Frame end: on the cycle after the last high phase, the following happen together:
  - `cs_n`=1 and `sclk`=0.
  - The shift register is copied to `data`.
  - `data_valid`=1 for one cycle.
  - `done`=1.
  - `data` never shows a partial frame.
- Triggers in CONV, WAIT or READ are ignored and set `overrun`. `overrun` clears on `overrun_clr`; if both happen in the same cycle, set wins.
- Triggers in IDLE or DONE with `en`=0 are ignored and do not set `overrun`.
- Deasserting `en` in any state returns to IDLE on the next cycle:
  - `convst`=0, `cs_n`=1, `sclk`=0, `done`=0.
  - `data` is held.
  - `error` and `overrun` are held.
- `rst` mid-acquisition: all outputs take their reset values on the next edge and no `data_valid` is emitted.
- `error` clears when a trigger is accepted.

## Timing
- Trigger sampled at cycle T: `convst`=1 for cycles T+1 … T+CONVST_W. WAIT starts at T+CONVST_W+1.
- If `busy`=0 is first seen at cycle W (W ≥ WAIT start + 2), READ starts at W+1.
- READ lasts 2*SCLK_DIV*N_WORDS*WORD_W cycles. `done` and `data_valid` go high on the following cycle.
- Minimum trigger-to-`done` latency: CONVST_W + 3 + 2*SCLK_DIV*N_WORDS*WORD_W + 1 cycles.
- Trigger accepted in DONE at cycle T: `done`=0 from T+1.

## Configuration
- `SENSOR_ACQ_TIMEOUT_EN` defined:
  - WAIT counts cycles from WAIT entry, including guard cycles.
  - When the count reaches `timeout_cycles` while `busy`=1, the block enters DONE with `done`=1 and `error`=1.
  - On timeout there is no `data_valid` pulse and `data` is held.
  - `timeout_cycles`=0 means the timeout fires on the first WAIT cycle.
- Not defined:
  - WAIT waits indefinitely.
  - `error` is tied to 0 and `timeout_cycles` is unused.

## Test plan
- N_WORDS=1, WORD_W=8, SCLK_DIV=2, CONVST_W=2, `busy` low, `miso` pattern 0xA5. Trigger at T → `convst` high at T+1..T+2, `cs_n` low T+6..T+37, `data`=0xA5, `data_valid` and `done` at T+38.
- `busy` high for 10 cycles after CONV → READ starts the cycle after `busy` is first seen low. A second trigger during READ → `overrun`=1, no restart, frame unaffected.
- `en` dropped mid-READ → next cycle `cs_n`=1, `done`=0, `data` unchanged. A later trigger with `en`=1 yields a complete new frame.
- With `SENSOR_ACQ_TIMEOUT_EN` defined, `timeout_cycles`=20, `busy` stuck high → `done`=1 and `error`=1 at WAIT entry +20, no `data_valid`. The next good acquisition clears `error`.
- Back-to-back: trigger in DONE → `done` falls the next cycle and rises again after the full latency, giving one rising edge per frame.
- `rst` asserted mid-CONV → all outputs at reset values on the next cycle; a trigger one cycle after `rst` deasserts is accepted.

Source files
------------

// File: rtl/sensor_acq_responder.sv
// Sensor-side trigger/done responder: CONVST pulse, BUSY wait, serial frame read, level done.
// Optional BUSY-wait timeout enabled by defining SENSOR_ACQ_TIMEOUT_EN.
module sensor_acq_responder #(
    parameter int N_WORDS  = 4,
    parameter int WORD_W   = 16,
    parameter int SCLK_DIV = 4,
    parameter int CONVST_W = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        trigger,
    input  logic                        en,
    input  logic [15:0]                 timeout_cycles,
    input  logic                        overrun_clr,
    input  logic                        busy,
    input  logic                        miso,
    output logic                        convst,
    output logic                        cs_n,
    output logic                        sclk,
    output logic [N_WORDS*WORD_W-1:0]   data,
    output logic                        data_valid,
    output logic                        done,
    output logic                        error,
    output logic                        overrun
);
    localparam int FRAME_W = N_WORDS * WORD_W;
    localparam int BIT_CW  = $clog2(FRAME_W + 1);
    localparam int DIV_CW  = $clog2(SCLK_DIV + 1);
    localparam int CONV_CW = $clog2(CONVST_W + 1);
    localparam logic [DIV_CW-1:0]  DIV_LAST  = DIV_CW'(SCLK_DIV - 1);
    localparam logic [BIT_CW-1:0]  BIT_LAST  = BIT_CW'(FRAME_W - 1);
    localparam logic [CONV_CW-1:0] CONV_LAST = CONV_CW'(CONVST_W - 1);

    typedef enum logic [2:0] {S_IDLE, S_CONV, S_WAIT, S_READ, S_DONE} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [CONV_CW-1:0]   r_conv_cnt;
    logic [15:0]          r_wait_cnt;
    logic [DIV_CW-1:0]    r_div;
    logic                 r_phase;
    logic [BIT_CW-1:0]    r_bit;
    logic [FRAME_W-1:0]   r_shift;
    logic [FRAME_W-1:0]   r_data;
    logic                 r_data_valid;
    logic                 r_overrun;

    logic w_accept;
    logic w_in_acq;
    logic w_sample;
    logic w_frame_end;
    logic w_guard_done;
    logic w_timeout;

    assign w_accept     = trigger & en & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_in_acq     = (r_state == S_CONV) | (r_state == S_WAIT) | (r_state == S_READ);
    assign w_sample     = (r_state == S_READ) & ~r_phase & (r_div == DIV_LAST);
    assign w_frame_end  = (r_state == S_READ) & r_phase & (r_div == DIV_LAST) & (r_bit == BIT_LAST);
    assign w_guard_done = (r_wait_cnt >= 16'd2);

`ifdef SENSOR_ACQ_TIMEOUT_EN
    logic r_error;

    // r_wait_cnt+1 is the number of WAIT cycles elapsed including the current one.
    assign w_timeout = (r_state == S_WAIT) & busy &
                       (({1'b0, r_wait_cnt} + 17'd1) >= {1'b0, timeout_cycles});

    always_ff @(posedge clk) begin
        if (rst)
            r_error <= 1'b0;
        else if (w_accept)
            r_error <= 1'b0;
        else if (w_timeout && en)
            r_error <= 1'b1;
    end
    assign error = r_error;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^timeout_cycles;
    assign w_timeout        = 1'b0;
    assign error            = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (!en) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (trigger) w_state_next = S_CONV;
                S_CONV: if (r_conv_cnt == CONV_LAST) w_state_next = S_WAIT;
                S_WAIT: begin
                    if (w_timeout)
                        w_state_next = S_DONE;
                    else if (w_guard_done && !busy)
                        w_state_next = S_READ;
                end
                S_READ: if (w_frame_end) w_state_next = S_DONE;
                S_DONE: if (trigger) w_state_next = S_CONV;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_conv_cnt   <= '0;
            r_wait_cnt   <= '0;
            r_div        <= '0;
            r_phase      <= 1'b0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_data       <= '0;
            r_data_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_conv_cnt <= (r_state == S_CONV) ? r_conv_cnt + 1'b1 : '0;
            if (r_state != S_WAIT)
                r_wait_cnt <= '0;
            else if (r_wait_cnt != 16'hFFFF)
                r_wait_cnt <= r_wait_cnt + 16'd1;

            // Bit timing: SCLK_DIV low cycles then SCLK_DIV high cycles per bit.
            if (r_state != S_READ) begin
                r_div   <= '0;
                r_phase <= 1'b0;
                r_bit   <= '0;
            end else if (r_div == DIV_LAST) begin
                r_div   <= '0;
                r_phase <= ~r_phase;
                if (r_phase)
                    r_bit <= r_bit + 1'b1;
            end else begin
                r_div <= r_div + 1'b1;
            end

            if (w_sample)
                r_shift <= (r_shift << 1) | FRAME_W'(miso);

            r_data_valid <= 1'b0;
            if (w_frame_end && en) begin
                r_data       <= r_shift;
                r_data_valid <= 1'b1;
            end

            if (trigger && w_in_acq)
                r_overrun <= 1'b1;
            else if (overrun_clr)
                r_overrun <= 1'b0;
        end
    end

    assign convst     = (r_state == S_CONV);
    assign cs_n       = (r_state != S_READ);
    assign sclk       = (r_state == S_READ) & r_phase;
    assign done       = (r_state == S_DONE);
    assign data       = r_data;
    assign data_valid = r_data_valid;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_sensor_acq_responder.sv
// Directed bench for sensor_acq_responder with a small SPI slave model driving miso.
// Defining SENSOR_ACQ_TIMEOUT_EN also runs the BUSY-timeout scenario.
module tb_sensor_acq_responder;
    localparam int N_WORDS  = 1;
    localparam int WORD_W   = 8;
    localparam int SCLK_DIV = 2;
    localparam int CONVST_W = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        trigger;
    logic        en;
    logic [15:0] timeout_cycles;
    logic        overrun_clr;
    logic        busy;
    logic        miso;
    logic        convst;
    logic        cs_n;
    logic        sclk;
    logic [7:0]  data;
    logic        data_valid;
    logic        done;
    logic        error;
    logic        overrun;

    int         cyc;
    int         n_total;
    int         n_bad;
    logic [7:0] slave_frame;

    sensor_acq_responder #(
        .N_WORDS(N_WORDS), .WORD_W(WORD_W), .SCLK_DIV(SCLK_DIV), .CONVST_W(CONVST_W)
    ) dut (
        .clk(clk), .rst(rst), .trigger(trigger), .en(en),
        .timeout_cycles(timeout_cycles), .overrun_clr(overrun_clr),
        .busy(busy), .miso(miso), .convst(convst), .cs_n(cs_n), .sclk(sclk),
        .data(data), .data_valid(data_valid), .done(done), .error(error),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Slave: presents MSB when selected, advances one bit after each sclk rising edge.
    initial begin
        int   idx;
        logic prev;
        idx  = 0;
        prev = 1'b0;
        miso = 1'b0;
        forever begin
            @(negedge clk);
            if (cs_n)
                idx = 0;
            else if (sclk && !prev)
                idx++;
            prev = sclk;
            miso = (idx < 8) ? slave_frame[7-idx] : 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got=%0h exp=%0h", tag, cyc, got, exp);
        end else begin
            $display("ok   %s @cyc %0d: %0h", tag, cyc, got);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int u;
        n_total = 0;
        n_bad   = 0;
        cyc     = 0;
        rst = 1'b1; trigger = 1'b0; en = 1'b1; overrun_clr = 1'b0;
        busy = 1'b0; timeout_cycles = 16'd20; slave_frame = 8'h00;
        tick(); tick();
        chk("rst_convst", convst, 0);
        chk("rst_cs_n", cs_n, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_data", data, 0);
        chk("rst_dv", data_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b0;
        tick();

        // Basic frame 0xA5, busy low
        t = cyc; slave_frame = 8'hA5;
        trigger = 1'b1; tick(); trigger = 1'b0;
        chk("t1_convst_T1", convst, 1);
        tick();
        chk("t1_convst_T2", convst, 1);
        run_to(t + 3);  chk("t1_convst_T3", convst, 0);
        run_to(t + 5);  chk("t1_csn_T5", cs_n, 1);
        run_to(t + 6);  chk("t1_csn_T6", cs_n, 0);
                        chk("t1_sclk_T6", sclk, 0);
        run_to(t + 8);  chk("t1_sclk_T8", sclk, 1);
        run_to(t + 37); chk("t1_csn_T37", cs_n, 0);
                        chk("t1_done_T37", done, 0);
                        chk("t1_data_T37", data, 0);
        run_to(t + 38); chk("t1_csn_T38", cs_n, 1);
                        chk("t1_data_T38", data, 8'hA5);
                        chk("t1_dv_T38", data_valid, 1);
                        chk("t1_done_T38", done, 1);
        run_to(t + 39); chk("t1_dv_T39", data_valid, 0);
                        chk("t1_done_T39", done, 1);

        // Back-to-back from DONE, busy high 10 cycles, overrun during READ
        t = cyc; slave_frame = 8'h3C; busy = 1'b1;
        trigger = 1'b1; tick(); trigger = 1'b0;
        chk("t2_done_fall", done, 0);
        run_to(t + 13); busy = 1'b0;
                        chk("t2_csn_T13", cs_n, 1);
        run_to(t + 14); chk("t2_csn_T14", cs_n, 0);
        run_to(t + 20); trigger = 1'b1; tick(); trigger = 1'b0;
        chk("t2_overrun", overrun, 1);
        chk("t2_no_restart_cs", cs_n, 0);
        chk("t2_no_restart_cv", convst, 0);
        run_to(t + 45); chk("t2_done_T45", done, 0);
        run_to(t + 46); chk("t2_done_T46", done, 1);
                        chk("t2_data", data, 8'h3C);
                        chk("t2_dv", data_valid, 1);
        overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
        chk("t2_overrun_clr", overrun, 0);

        // en dropped mid-READ, then a fresh complete frame
        t = cyc; slave_frame = 8'hFF;
        trigger = 1'b1; tick(); trigger = 1'b0;
        run_to(t + 15); en = 1'b0; tick();
        chk("t3_abort_csn", cs_n, 1);
        chk("t3_abort_sclk", sclk, 0);
        chk("t3_abort_done", done, 0);
        chk("t3_abort_data", data, 8'h3C);
        en = 1'b1;
        run_to(t + 20);
        u = cyc; slave_frame = 8'h5A;
        trigger = 1'b1; tick(); trigger = 1'b0;
        run_to(u + 37); chk("t3_data_hold", data, 8'h3C);
                        chk("t3_done_T37", done, 0);
        run_to(u + 38); chk("t3_data_new", data, 8'h5A);
                        chk("t3_done_T38", done, 1);

        // Reset mid-CONV with overrun set, then immediate retrigger
        t = cyc; slave_frame = 8'h81;
        trigger = 1'b1; tick(); tick(); trigger = 1'b0;
        chk("t4_overrun_set", overrun, 1);
        chk("t4_convst_T2", convst, 1);
        rst = 1'b1; tick();
        chk("t4_rst_convst", convst, 0);
        chk("t4_rst_overrun", overrun, 0);
        chk("t4_rst_data", data, 0);
        chk("t4_rst_done", done, 0);
        chk("t4_rst_csn", cs_n, 1);
        rst = 1'b0; tick();
        u = cyc;
        trigger = 1'b1; tick(); trigger = 1'b0;
        chk("t4_convst_after", convst, 1);
        run_to(u + 38); chk("t4_done", done, 1);
                        chk("t4_data", data, 8'h81);
                        chk("t4_dv", data_valid, 1);

`ifdef SENSOR_ACQ_TIMEOUT_EN
        // BUSY stuck high: timeout at WAIT entry + 20
        t = cyc; busy = 1'b1;
        trigger = 1'b1; tick(); trigger = 1'b0;
        run_to(t + 22); chk("t5_done_T22", done, 0);
        run_to(t + 23); chk("t5_done_T23", done, 1);
                        chk("t5_error", error, 1);
                        chk("t5_dv", data_valid, 0);
                        chk("t5_data_hold", data, 8'h81);
        busy = 1'b0; slave_frame = 8'h66;
        u = cyc;
        trigger = 1'b1; tick(); trigger = 1'b0;
        chk("t5_error_clr", error, 0);
        run_to(u + 38); chk("t5_done_good", done, 1);
                        chk("t5_data_good", data, 8'h66);
`else
        chk("t5_error_tied", error, 0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
